// File: rtl/ma_store_buffer.sv
// Memory-access-stage store buffer: a circular FIFO of pending stores that drains to data memory
// in idle cycles, forwards buffered data to loads, and stalls the pipeline when full.
module ma_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       isLd,
  input  logic                       isSt,
  input  logic [AW-1:0]              address,
  input  logic [DW-1:0]              data_in,
  output logic [DW-1:0]              data_out,
  output logic                       stall,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count,
  output logic                       mem_isLd,
  output logic                       mem_isSt,
  output logic [AW-1:0]              mem_address,
  output logic [DW-1:0]              mem_data_in,
  input  logic [DW-1:0]              mem_data_out
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;

  logic          full;
  logic          enq;
  logic          drain;
  logic          ld_act;
  logic          hit;
  logic [DW-1:0] fwd_data;

  always_comb begin
    full   = (count_q == CW'(DEPTH));
    enq    = rst_n & isSt & ~full;
    // Drain only when the port is free (idle) or to make room for a stalled store.
    drain  = rst_n & (count_q != '0) & ((~isLd & ~isSt) | (isSt & full));
    // A simultaneous load and store is treated as a store only.
    ld_act = rst_n & isLd & ~isSt;
    stall  = rst_n & isSt & full;
  end

  // Scan from oldest to youngest so the last matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < count_q) && valid_q[head_q + PW'(i)] &&
          (addr_q[head_q + PW'(i)] == address)) begin
        hit      = 1'b1;
        fwd_data = data_q[head_q + PW'(i)];
      end
    end
  end

  always_comb begin
    data_out    = '0;
    mem_isLd    = ld_act;
    mem_isSt    = drain;
    mem_address = '0;
    mem_data_in = '0;
    if (ld_act) begin
      data_out    = hit ? fwd_data : mem_data_out;
      mem_address = address;
    end else if (drain) begin
      mem_address = addr_q[head_q];
      mem_data_in = data_q[head_q];
    end
    sb_empty = ~rst_n | (count_q == '0);
    sb_count = count_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(enq) - CW'(drain);
    end
  end

  // Payload storage needs no reset; valid bits and count qualify every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= address;
      data_q[tail_q] <= data_in;
    end
  end

endmodule
